// File: rtl/pc_btb_gen_pkg.sv
// Shared types and constants for the fetch PC generator and its branch target buffer.
// Widths are fixed here so that the BTB entry struct and every module agree on them.
package pc_btb_gen_pkg;

  localparam int AW = 30;
  localparam logic [AW-1:0] RESET_PC = 30'h0000_0C0D;
  localparam int BTB_DEPTH = 16;
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = AW - IDX_W;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [AW-1:0]    target;
    ctr_e             ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_inc(input ctr_e c);
    return (c == ST) ? ST : ctr_e'(c + 2'b01);
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    return (c == SNT) ? SNT : ctr_e'(c - 2'b01);
  endfunction

endpackage

// File: rtl/pc_btb_gen_btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup for the current fetch PC,
// and training from EX-stage branch resolution.
module btb_dm
  import pc_btb_gen_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] lk_pc,
  input  logic          upd_en,
  input  logic [AW-1:0] upd_pc,
  input  logic [AW-1:0] upd_target,
  input  logic          upd_taken,
  output logic          pred_taken,
  output logic [AW-1:0] pred_target
);

  btb_entry_t tbl [BTB_DEPTH];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  btb_entry_t       lk_ent;
  logic             lk_hit;

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  btb_entry_t       u_ent;
  logic             u_hit;

  assign lk_idx = lk_pc[IDX_W-1:0];
  assign lk_tag = lk_pc[AW-1:IDX_W];
  assign lk_ent = tbl[lk_idx];
  assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);

  // Lookup reads pre-update contents; a same-entry write only lands at the edge.
  assign pred_taken  = lk_hit && lk_ent.ctr[1];
  assign pred_target = pred_taken ? lk_ent.target : '0;

  assign u_idx = upd_pc[IDX_W-1:0];
  assign u_tag = upd_pc[AW-1:IDX_W];
  assign u_ent = tbl[u_idx];
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

  // NOTE: the table is flops, not RAM, so every entry can be cleared in one reset
  // cycle; valid bits must start at 0 and counters at weakly-not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
    end else if (upd_en) begin
      if (u_hit) begin
        if (upd_taken) begin
          tbl[u_idx].ctr    <= ctr_inc(u_ent.ctr);
          tbl[u_idx].target <= upd_target;
        end else begin
          tbl[u_idx].ctr <= ctr_dec(u_ent.ctr);
        end
      end else if (upd_taken) begin
        tbl[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target, ctr: WT};
      end
    end
  end

endmodule

// File: rtl/pc_btb_gen.sv
// Fetch PC generator: PC register, pending-redirect register and next-PC selection,
// with in-block branch prediction from a direct-mapped BTB.
module pc_btb_gen
  import pc_btb_gen_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          hazard,
  input  logic          branch_bubble,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          upd_en,
  input  logic [AW-1:0] upd_pc,
  input  logic [AW-1:0] upd_target,
  input  logic          upd_taken,
  output logic [AW-1:0] pc,
  output logic          pred_taken,
  output logic [AW-1:0] pred_target
);

  logic          hold;
  logic          pend_v;
  logic [AW-1:0] pend_pc;

  assign hold = hazard | branch_bubble;

  btb_dm u_btb (
    .clk         (clk),
    .rst         (rst),
    .lk_pc       (pc),
    .upd_en      (upd_en),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );

  // A redirect arriving while fetch is held is parked in pend_pc so it is not lost;
  // the newest one wins and is applied at the first unheld edge.
  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      pend_v  <= 1'b0;
      pend_pc <= '0;
    end else if (hold) begin
      if (redirect) begin
        pend_v  <= 1'b1;
        pend_pc <= redirect_pc;
      end
    end else if (redirect) begin
      pc     <= redirect_pc;
      pend_v <= 1'b0;
    end else if (pend_v) begin
      pc     <= pend_pc;
      pend_v <= 1'b0;
    end else if (pred_taken) begin
      pc <= pred_target;
    end else begin
      pc <= pc + AW'(1);
    end
  end

endmodule

// File: doc/pc_btb_gen.md
Name: pc_btb_gen

Overview:
- Parametrised fetch PC generator; successor to the single-register PC with external predict input.
- Holds the word-addressed fetch PC and selects the next PC.
- Contains an internal direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so prediction is produced in-block.
- Sits at the head of the IF stage. Is fed by hazard/branch-bubble stall signals and by EX-stage branch resolution (redirect and BTB update).

Parameters:
- AW, 30, PC width in words (byte address bits [AW+1:2]).
- RESET_PC, 30'h0000_0C0D, word address loaded on reset (byte 0x0000_3034).
- BTB_DEPTH, 16, number of BTB entries; power of two, at least 2.
- IDX_W, log2(BTB_DEPTH), derived, index width.
- TAG_W, AW-IDX_W, derived, tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- hazard  in  1  load-use stall; hold PC.
- branch_bubble  in  1  branch bubble; hold PC.
- redirect  in  1  EX says the fetch path was wrong; load redirect_pc.
- redirect_pc  in  AW  corrected fetch word address.
- upd_en  in  1  EX resolved a branch; train the BTB.
- upd_pc  in  AW  word address of the resolved branch.
- upd_target  in  AW  resolved target.
- upd_taken  in  1  resolved direction.
- pc  out  AW  current fetch word address (registered).
- pred_taken  out  1  BTB predicts taken for pc (combinational from pc and BTB).
- pred_target  out  AW  predicted target; valid when pred_taken=1, otherwise 0.

Behaviour:
- Reset: rst is synchronous, active-high, and sampled on the rising edge of clk.
  - rst has highest priority and is NOT gated by hazard or branch_bubble.
  - On reset: pc=RESET_PC, pending redirect cleared, all BTB valid bits 0, all counters 2'b01.
  - After reset: pred_taken=0, pred_target=0.
- hold = hazard | branch_bubble.
- Next-PC priority at each edge with rst=0:
  1. hold=1: pc unchanged. If redirect=1, capture redirect_pc into the pending register (pend_v=1, pend_pc); a newer redirect overwrites an older one.
  2. redirect=1: pc=redirect_pc; pend_v cleared.
  3. pend_v=1: pc=pend_pc; pend_v cleared.
  4. pred_taken=1: pc=pred_target.
  5. Otherwise pc=pc+1, modulo 2^AW (all-ones wraps to 0).
- Latency: a redirect in an unheld cycle takes effect at the next edge (1 cycle). A redirect in a held cycle takes effect at the first unheld edge.
- BTB lookup: idx=pc[IDX_W-1:0], tag=pc[AW-1:IDX_W]. hit = valid[idx] & tag match. pred_taken = hit & ctr[idx][1].
- BTB update on upd_en=1, independent of hold; it is also performed during rst=0 redirect cycles.
  - Entry hit, upd_taken=1: ctr saturating increment (max 2'b11); target<=upd_target.
  - Entry hit, upd_taken=0: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, upd_taken=1: allocate/replace the entry with valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss, upd_taken=0: no change.
- Same-entry read/write in one cycle: the lookup sees pre-update contents; the write lands at the edge.
- rst=1 together with upd_en=1: reset wins; the update is discarded.
- No other BTB write paths. Storage is flops (small depth), not inferred RAM.

Decomposition:
- Shared package: AW, RESET_PC, counter encodings (SNT=00, WNT=01, WT=10, ST=11), the saturating increment/decrement function, and the BTB entry struct {valid, tag, target, ctr}.
- One sub-module, btb_dm: lookup plus update logic. The top contains the PC register, pending-redirect register and next-PC mux.

Test Plan:
- Reset and sequential fetch: rst for 1 cycle, then release -> pc=0x0C0D, then 0x0C0E, 0x0C0F. Hold pc at 0x3FFF_FFFF -> next pc 0x0000_0000.
- Reset during hold: hazard=1 with rst=1 -> pc=0x0C0D at that edge (old design ignored this).
- Hold and redirect: branch_bubble=1 with redirect=1 and redirect_pc=0x100, held 2 cycles -> pc unchanged. First unheld edge -> pc=0x100.
- Redirect priority over prediction: pc hits a taken entry (target 0x200) while redirect=1 with redirect_pc=0x300 -> pc=0x300.
- BTB train and predict (BTB_DEPTH=16):
  - upd_en, upd_pc=0x0C10, upd_target=0x0C40, upd_taken=1 -> entry ctr=10.
  - Later, when pc reaches 0x0C10 -> pred_taken=1, next pc=0x0C40.
  - Two not-taken updates -> ctr=00 -> fall-through to 0x0C11.
- Alias and saturation:
  - Train 0x0C10 to 11, then train taken 0x0C20 (same index, different tag) -> entry replaced, ctr=10, and 0x0C10 lookup misses.
  - A third taken update on a ctr=11 entry keeps ctr=11.
